// File: rtl/cgra_sram_banked_ret_ctrl.sv
// Banked, word-interleaved CGRA data memory with per-bank idle/forced
// retention and demand wake-up. Requests stall on gnt_o until the bank is ACTIVE.
module cgra_sram_banked_ret_ctrl #(
  parameter int NumWords   = 1024,
  parameter int DataWidth  = 32,
  parameter int NumBanks   = 4,
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 4
) (
  input  logic                                           clk_i,
  input  logic                                           rst_i,
  input  logic                                           req_i,
  input  logic                                           we_i,
  input  logic [$clog2(NumBanks)+$clog2(NumWords)-1:0]   addr_i,
  input  logic [DataWidth-1:0]                           wdata_i,
  input  logic [DataWidth/8-1:0]                         be_i,
  input  logic                                           force_ret_i,
  output logic                                           gnt_o,
  output logic                                           rvalid_o,
  output logic [DataWidth-1:0]                           rdata_o,
  output logic [NumBanks-1:0]                            bank_ret_o
);

  localparam int BankBits  = $clog2(NumBanks);
  localparam int RowBits   = $clog2(NumWords);
  localparam int AddrWidth = BankBits + RowBits;
  localparam int IdleW     = (IdleCycles > 0) ? $clog2(IdleCycles + 1) : 1;
  localparam int WakeW     = (WakeCycles > 1) ? $clog2(WakeCycles) : 1;

  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_RET,
    ST_WAKE
  } bank_state_e;

  bank_state_e          state_q [NumBanks];
  bank_state_e          state_d [NumBanks];
  logic [IdleW-1:0]     idle_q  [NumBanks];
  logic [IdleW-1:0]     idle_d  [NumBanks];
  logic [WakeW-1:0]     wake_q  [NumBanks];
  logic [WakeW-1:0]     wake_d  [NumBanks];

  logic [BankBits-1:0]  bank_sel;
  logic [RowBits-1:0]   row_sel;
  logic [NumBanks-1:0]  bank_hit;
  logic [NumBanks-1:0]  bank_req;
  logic [DataWidth-1:0] bank_rdata [NumBanks];

  logic                 rvalid_q, rvalid_d;
  logic [BankBits-1:0]  rd_bank_q, rd_bank_d;
  logic [DataWidth-1:0] hold_q, hold_d;
  logic [DataWidth-1:0] rdata_mux;

  assign bank_sel = addr_i[BankBits-1:0];
  assign row_sel  = addr_i[AddrWidth-1:BankBits];
  assign gnt_o    = |bank_req;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    // SRAM macro model: storage and read register carry no reset
    logic [DataWidth-1:0] mem_q [NumWords];
    logic [DataWidth-1:0] rdata_q;
    logic [DataWidth-1:0] wword_d;
    logic                 set_retentive_n;

    assign bank_hit[b]     = req_i && (bank_sel == BankBits'(b));
    assign bank_req[b]     = bank_hit[b] && (state_q[b] == ST_ACTIVE);
    assign set_retentive_n = (state_q[b] != ST_RET);
    assign bank_ret_o[b]   = !set_retentive_n;
    assign bank_rdata[b]   = rdata_q;

    always_comb begin
      wword_d = mem_q[row_sel];
      for (int unsigned i = 0; i < DataWidth / 8; i++) begin
        if (be_i[i]) wword_d[8*i +: 8] = wdata_i[8*i +: 8];
      end
    end

    always_ff @(posedge clk_i) begin
      if (bank_req[b] && set_retentive_n) begin
        if (we_i) mem_q[row_sel] <= wword_d;
        else      rdata_q        <= mem_q[row_sel];
      end
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < NumBanks; b++) begin
      state_d[b] = state_q[b];
      idle_d[b]  = idle_q[b];
      wake_d[b]  = wake_q[b];
      unique case (state_q[b])
        ST_ACTIVE: begin
          // a grant beats both the idle timeout and force_ret_i
          if (bank_req[b]) begin
            idle_d[b] = '0;
          end else if (force_ret_i ||
                       (IdleCycles != 0 && idle_q[b] == IdleW'(IdleCycles - 1))) begin
            state_d[b] = ST_RET;
          end else if (idle_q[b] != IdleW'(IdleCycles)) begin
            idle_d[b] = idle_q[b] + 1'b1;
          end
        end
        ST_RET: begin
          if (bank_hit[b] && !force_ret_i) begin
            state_d[b] = ST_WAKE;
            wake_d[b]  = WakeW'(WakeCycles - 1);
          end
        end
        ST_WAKE: begin
          if (wake_q[b] == '0) begin
            state_d[b] = ST_ACTIVE;
            idle_d[b]  = '0;
          end else begin
            wake_d[b] = wake_q[b] - 1'b1;
          end
        end
        default: state_d[b] = ST_ACTIVE;
      endcase
    end
  end

  always_comb begin
    rvalid_d  = gnt_o && !we_i;
    rd_bank_d = rvalid_d ? bank_sel : rd_bank_q;
    rdata_mux = bank_rdata[rd_bank_q];
    hold_d    = rvalid_q ? rdata_mux : hold_q;
    rdata_o   = rvalid_q ? rdata_mux : hold_q;
  end

  assign rvalid_o = rvalid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        state_q[b] <= ST_ACTIVE;
        idle_q[b]  <= '0;
        wake_q[b]  <= '0;
      end
      rvalid_q  <= 1'b0;
      rd_bank_q <= '0;
      hold_q    <= '0;
    end else begin
      for (int unsigned b = 0; b < NumBanks; b++) begin
        state_q[b] <= state_d[b];
        idle_q[b]  <= idle_d[b];
        wake_q[b]  <= wake_d[b];
      end
      rvalid_q  <= rvalid_d;
      rd_bank_q <= rd_bank_d;
      hold_q    <= hold_d;
    end
  end

endmodule

// File: tb/tb_cgra_sram_banked_ret_ctrl.sv
// Bench for cgra_sram_banked_ret_ctrl: vector table, directed retention/wake
// sequences, and a randomized run against a cycle-count based reference model.
module tb_cgra_sram_banked_ret_ctrl;

  localparam int NW = 1024;
  localparam int DW = 32;
  localparam int NB = 4;
  localparam int IC = 16;
  localparam int WC = 4;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, we, frc;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    be;
  logic          gnt, rvalid;
  logic [31:0]   rdata;
  logic [3:0]    bank_ret;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cgra_sram_banked_ret_ctrl #(
    .NumWords(NW), .DataWidth(DW), .NumBanks(NB), .IdleCycles(IC), .WakeCycles(WC)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .be_i(be), .force_ret_i(frc), .gnt_o(gnt),
    .rvalid_o(rvalid), .rdata_o(rdata), .bank_ret_o(bank_ret)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        egnt;
    logic        ervalid;
    logic [31:0] erdata;
  } vec_t;

  vec_t tbl [16];

  // reference model: bank usability is expressed as cycle numbers
  logic [31:0] mmem [0:4095];
  bit          m_ret [NB];
  int          m_idle [NB];
  int          m_ready_at [NB];
  int          cyc;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic f);
    req = r; we = w; addr = a; wdata = d; be = b; frc = f;
  endtask

  // leaves the bench at a negedge with reset just released
  task automatic do_reset();
    drive(0, 0, '0, '0, '0, 0);
    rst = 1'b1;
    #1;
    chk("reset_ret", 32'(bank_ret), 32'h0);
    chk("reset_rvalid", 32'(rvalid), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    m_rvalid = 1'b0;
    m_rdata = '0;
    for (int b = 0; b < NB; b++) begin
      m_ret[b] = 0; m_idle[b] = 0; m_ready_at[b] = 0;
    end
  endtask

  function automatic bit m_active(input int b);
    return !m_ret[b] && (cyc >= m_ready_at[b]);
  endfunction

  // entered and left at a negedge; one clock cycle per call
  task automatic mstep(input logic r, input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic [3:0] b, input logic f,
                       output logic g);
    int bk;
    logic [3:0] eret;
    bk = int'(a[1:0]);
    drive(r, w, a, d, b, f);
    #1;
    g = r && m_active(bk);
    for (int i = 0; i < NB; i++) eret[i] = m_ret[i];
    chk("rnd_gnt", 32'(gnt), 32'(g));
    chk("rnd_ret", 32'(bank_ret), 32'(eret));
    chk("rnd_rvalid", 32'(rvalid), 32'(m_rvalid));
    chk("rnd_rdata", rdata, m_rdata);
    @(posedge clk);
    for (int i = 0; i < NB; i++) begin
      if (m_active(i)) begin
        if (g && bk == i) m_idle[i] = 0;
        else if (f || (IC != 0 && m_idle[i] + 1 >= IC)) m_ret[i] = 1;
        else m_idle[i]++;
      end else if (m_ret[i]) begin
        if (r && bk == i && !f) begin
          m_ret[i] = 0;
          m_ready_at[i] = cyc + 1 + WC;
          m_idle[i] = 0;
        end
      end
    end
    m_rvalid = g && !w;
    if (g && !w) m_rdata = mmem[a];
    if (g && w) begin
      for (int i = 0; i < 4; i++) if (b[i]) mmem[a][8*i +: 8] = d[8*i +: 8];
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic w, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    logic g;
    int n;
    g = 0;
    n = 0;
    while (!g && n < 100) begin
      mstep(1, w, a, d, b, ($urandom % 8) == 0, g);
      n++;
    end
    chk("issue_done", 32'(g), 32'h1);
  endtask

  function automatic vec_t mk(input logic r, input logic w, input logic [11:0] a,
                              input logic [31:0] d, input logic [3:0] b,
                              input logic eg, input logic ev, input logic [31:0] ed);
    vec_t v;
    v.req = r; v.we = w; v.addr = a; v.wdata = d; v.be = b;
    v.egnt = eg; v.ervalid = ev; v.erdata = ed;
    return v;
  endfunction

  initial begin
    int n;
    logic g;
    tbl[0]  = mk(1, 1, 12'd5, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0);
    tbl[1]  = mk(1, 0, 12'd5, 32'h0,        4'h0, 1, 0, 32'h0);
    tbl[2]  = mk(0, 0, 12'd0, 32'h0,        4'h0, 0, 1, 32'hDEADBEEF);
    tbl[3]  = mk(1, 1, 12'd5, 32'h11223344, 4'hF, 1, 0, 32'hDEADBEEF);
    tbl[4]  = mk(1, 1, 12'd5, 32'hAABBCCDD, 4'h4, 1, 0, 32'hDEADBEEF);
    tbl[5]  = mk(1, 0, 12'd5, 32'h0,        4'h0, 1, 0, 32'hDEADBEEF);
    tbl[6]  = mk(1, 1, 12'd0, 32'hC0DE0000, 4'hF, 1, 1, 32'h11BB3344);
    tbl[7]  = mk(1, 1, 12'd1, 32'hC0DE0001, 4'hF, 1, 0, 32'h11BB3344);
    tbl[8]  = mk(1, 1, 12'd2, 32'hC0DE0002, 4'hF, 1, 0, 32'h11BB3344);
    tbl[9]  = mk(1, 1, 12'd3, 32'hC0DE0003, 4'hF, 1, 0, 32'h11BB3344);
    tbl[10] = mk(1, 0, 12'd0, 32'h0,        4'h0, 1, 0, 32'h11BB3344);
    tbl[11] = mk(1, 0, 12'd1, 32'h0,        4'h0, 1, 1, 32'hC0DE0000);
    tbl[12] = mk(1, 0, 12'd2, 32'h0,        4'h0, 1, 1, 32'hC0DE0001);
    tbl[13] = mk(1, 0, 12'd3, 32'h0,        4'h0, 1, 1, 32'hC0DE0002);
    tbl[14] = mk(0, 0, 12'd0, 32'h0,        4'h0, 0, 1, 32'hC0DE0003);
    tbl[15] = mk(0, 0, 12'd0, 32'h0,        4'h0, 0, 0, 32'hC0DE0003);

    // vector table: basic write/read, byte enables, back-to-back reads
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, 0);
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].egnt));
      chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].ervalid));
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].erdata);
      @(negedge clk);
    end

    // idle timeout then demand wake of bank 2
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (k == 15) chk("idle15_ret2", 32'(bank_ret[2]), 32'h0);
      if (k == 16) chk("idle16_ret2", 32'(bank_ret[2]), 32'h1);
    end
    drive(1, 0, 12'd2, '0, '0, 0);
    #1;
    n = 0;
    while (gnt !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wake_latency", n, 32'd5);
    @(negedge clk);
    drive(0, 0, '0, '0, '0, 0);
    #1;
    chk("wake_rvalid", 32'(rvalid), 32'h1);
    chk("wake_rdata", rdata, 32'hC0DE0002);

    // forced retention blocks wake while held
    do_reset();
    drive(0, 0, '0, '0, '0, 1);
    @(negedge clk);
    #1;
    chk("force_ret_all", 32'(bank_ret), 32'hF);
    drive(1, 0, 12'd0, '0, '0, 1);
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("force_no_gnt", 32'(gnt), 32'h0);
      @(negedge clk);
    end
    frc = 1'b0;
    #1;
    n = 0;
    while (gnt !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("force_release_latency", n, 32'd5);
    @(negedge clk);
    drive(0, 0, '0, '0, '0, 0);
    #1;
    chk("force_rdata", rdata, 32'hC0DE0000);

    // reset with a pending read response, then reset during WAKE
    do_reset();
    drive(1, 0, 12'd0, '0, '0, 0);
    #1;
    chk("rst_rd_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    drive(0, 0, '0, '0, '0, 0);
    #1;
    chk("rst_rd_rvalid", 32'(rvalid), 32'h1);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_drop_rvalid", 32'(rvalid), 32'h0);
    chk("rst_drop_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (16) @(negedge clk);
    #1;
    chk("all_idle_ret", 32'(bank_ret), 32'hF);
    drive(1, 0, 12'd1, '0, '0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("wake1_ret", 32'(bank_ret), 32'hD);
    chk("wake1_no_gnt", 32'(gnt), 32'h0);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_wake_ret", 32'(bank_ret), 32'h0);
    chk("rst_wake_rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wake_gnt", 32'(gnt), 32'h1);
    @(negedge clk);

    // randomized run against the reference model
    do_reset();
    for (int a = 0; a < 64; a++) issue(1, 12'(a), $urandom, 4'hF);
    for (int op = 0; op < 400; op++) begin
      if ($urandom_range(0, 9) < 2) begin
        logic f;
        f = ($urandom % 4) == 0;
        n = $urandom_range(1, 25);
        for (int k = 0; k < n; k++) mstep(0, 0, '0, '0, '0, f, g);
      end else begin
        issue($urandom_range(0, 1) == 1, 12'($urandom_range(0, 63)), $urandom,
              4'($urandom_range(0, 15)));
      end
    end
    mstep(0, 0, '0, '0, '0, 0, g);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
